regfile_seq: RTL and testbench

REGFILE_SEQ -- requirements
Module: regfile_seq

---
 rtl/regfile_seq.sv | 132 +++++++++++++
 tb/tb_regfile_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/regfile_seq.sv
// Sequences one register-file read / execute / write-back operation: 5-cycle start-to-done latency, plus one cycle per extra EXEC cycle.
// ready is high only in IDLE, and start is ignored otherwise; the execution unit is given 256 EXEC cycles before the op ends with err.
module regfile_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  dst,
    input  logic [3:0]  src1,
    input  logic [3:0]  src2,
    output logic        ready,
    output logic        EN,
    output logic        RD,
    output logic        WR,
    output logic [3:0]  so1,
    output logic [3:0]  so2,
    output logic [3:0]  si1,
    output logic [63:0] I1,
    input  logic [63:0] O1,
    input  logic [63:0] O2,
    output logic        ex_valid,
    output logic [63:0] ex_a,
    output logic [63:0] ex_b,
    input  logic        ex_done,
    input  logic [63:0] ex_result,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RDREQ = 3'd1,
        RDCAP = 3'd2,
        EXEC  = 3'd3,
        WB    = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  dst_q, dst_d;
    logic [3:0]  src1_q, src1_d;
    logic [3:0]  src2_q, src2_d;
    logic [63:0] opa_q, opa_d;
    logic [63:0] opb_q, opb_d;
    logic [63:0] res_q, res_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dst_q   <= 4'd0;
            src1_q  <= 4'd0;
            src2_q  <= 4'd0;
            opa_q   <= 64'd0;
            opb_q   <= 64'd0;
            res_q   <= 64'd0;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dst_q   <= dst_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dst_d   = dst_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dst_d   = dst;
                    src1_d  = src1;
                    src2_d  = src2;
                    err_d   = 1'b0;
                    state_d = RDREQ;
                end
            end
            RDREQ: state_d = RDCAP;
            RDCAP: begin
                // Read data is valid one cycle after the RD strobe.
                opa_d   = O1;
                opb_d   = O2;
                cnt_d   = 8'd0;
                state_d = EXEC;
            end
            EXEC: begin
                cnt_d = cnt_q + 8'd1;
                if (ex_done) begin
                    res_d   = ex_result;
                    state_d = WB;
                end else if (cnt_q == 8'd255) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            WB:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready    = (state_q == IDLE);
        EN       = (state_q == RDREQ) || (state_q == RDCAP) || (state_q == WB);
        RD       = (state_q == RDREQ);
        WR       = (state_q == WB);
        so1      = ((state_q == RDREQ) || (state_q == RDCAP)) ? src1_q : 4'd0;
        so2      = ((state_q == RDREQ) || (state_q == RDCAP)) ? src2_q : 4'd0;
        si1      = (state_q == WB) ? dst_q : 4'd0;
        I1       = (state_q == WB) ? res_q : 64'd0;
        ex_valid = (state_q == EXEC);
        ex_a     = (state_q == EXEC) ? opa_q : 64'd0;
        ex_b     = (state_q == EXEC) ? opb_q : 64'd0;
        done     = (state_q == DONE);
        err      = (state_q == DONE) && err_q;
    end

endmodule

// File: tb/tb_regfile_seq.sv
// Bench for regfile_seq: register file and execution unit modelled here, with a shadow register array as the reference.
module tb_regfile_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  dst = 4'd0, src1 = 4'd0, src2 = 4'd0;
    logic        ready, EN, RD, WR, ex_valid, done, err;
    logic [3:0]  so1, so2, si1;
    logic [63:0] I1, ex_a, ex_b;
    logic [63:0] O1 = 64'd0, O2 = 64'd0;
    logic        ex_done = 1'b0;
    logic [63:0] ex_result = 64'd0;

    logic [63:0] rf [16];
    logic [63:0] exp_reg [16];
    logic        pl_we = 1'b0;
    logic [3:0]  pl_addr = 4'd0;
    logic [63:0] pl_dat = 64'd0;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    bit rdwr_bad = 1'b0;

    regfile_seq dut (
        .clk(clk), .rst(rst), .start(start), .dst(dst), .src1(src1), .src2(src2),
        .ready(ready), .EN(EN), .RD(RD), .WR(WR), .so1(so1), .so2(so2), .si1(si1),
        .I1(I1), .O1(O1), .O2(O2), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
        .ex_done(ex_done), .ex_result(ex_result), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Synchronous-read register file: data appears the cycle after RD.
    always @(posedge clk) begin
        if (pl_we) rf[pl_addr] <= pl_dat;
        else if (EN && WR) rf[si1] <= I1;
        if (EN && RD) begin
            O1 <= rf[so1];
            O2 <= rf[so2];
        end
    end

    always @(negedge clk) begin
        if (WR) wr_cnt++;
        if (RD && WR) rdwr_bad = 1'b1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic preload(input logic [3:0] a, input logic [63:0] v);
        @(negedge clk);
        pl_we = 1'b1; pl_addr = a; pl_dat = v;
        @(negedge clk);
        pl_we = 1'b0;
        exp_reg[a] = v;
    endtask

    // dly < 0: ex_done never comes. rst_at > 0: reset in that EXEC cycle.
    task automatic run_op(input logic [3:0] d, input logic [3:0] s1, input logic [3:0] s2,
                          input int dly, input logic [63:0] res, input bit hold, input int rst_at);
        int cyc, exec_n, done_cyc, nexec, edone, wr0;
        bit to, sched_bad, stable_bad, rst_hit, err_seen;
        logic [63:0] ea, eb, fa, fb;
        logic [5:0] ev;
        to = (dly < 0);
        nexec = to ? 256 : dly + 1;
        edone = to ? 3 + nexec : 4 + nexec;
        ea = exp_reg[s1]; eb = exp_reg[s2];
        fa = 64'd0; fb = 64'd0;
        exec_n = 0; done_cyc = 0; sched_bad = 0; stable_bad = 0; rst_hit = 0; err_seen = 0;
        @(negedge clk);
        chk("ready_before_start", {63'd0, ready}, 64'd1);
        wr0 = wr_cnt;
        start = 1'b1; dst = d; src1 = s1; src2 = s2; ex_done = 1'b0;
        @(negedge clk);
        cyc = 1;
        if (!hold) start = 1'b0;
        dst = 4'($urandom); src1 = 4'($urandom); src2 = 4'($urandom);
        while (1) begin
            if (ex_valid) begin
                exec_n++;
                if (exec_n == 1) begin fa = ex_a; fb = ex_b; end
                else if (ex_a !== fa || ex_b !== fb) stable_bad = 1'b1;
            end
            ev = 6'b000000;
            if (cyc == 1) ev = 6'b011000;
            else if (cyc == 2) ev = 6'b010000;
            else if (cyc < 3 + nexec) ev = 6'b000010;
            else if (!to && cyc == 3 + nexec) ev = 6'b010100;
            else if (cyc == edone) ev = 6'b000001;
            if ({ready, EN, RD, WR, ex_valid, done} !== ev) sched_bad = 1'b1;
            if ((cyc == 1 || cyc == 2) && (so1 !== s1 || so2 !== s2)) sched_bad = 1'b1;
            if (WR && (si1 !== d || I1 !== res)) sched_bad = 1'b1;
            if (done) begin done_cyc = cyc; err_seen = err; break; end
            if (rst_at > 0 && ex_valid && exec_n == rst_at) begin rst_hit = 1'b1; break; end
            if (cyc >= 400) break;
            if (ex_valid) begin
                ex_done = !to && (exec_n == dly + 1);
                ex_result = ex_done ? res : {$urandom, $urandom};
            end else begin
                ex_done = 1'($urandom);
                ex_result = {$urandom, $urandom};
            end
            @(negedge clk);
            cyc++;
        end
        ex_done = 1'b0;
        if (rst_hit) begin
            rst = 1'b1; start = 1'b1;
            @(negedge clk);
            chk("rst_mid_exec_outputs", {57'd0, ready, EN, RD, WR, ex_valid, done, err}, 64'h40);
            rst = 1'b0; start = 1'b0;
            done_cyc = 0;
            repeat (4) begin
                @(negedge clk);
                if (done || !ready) done_cyc++;
            end
            chk("rst_no_done_stays_idle", done_cyc, 0);
            chk("rst_no_write", wr_cnt - wr0, 0);
            chk("rst_rf_unchanged", rf[d], exp_reg[d]);
            return;
        end
        chk("done_latency", done_cyc, edone);
        chk("err_flag", {63'd0, err_seen}, {63'd0, to});
        chk("strobe_schedule", {63'd0, sched_bad}, 64'd0);
        chk("ex_a", fa, ea);
        chk("ex_b", fb, eb);
        chk("operands_stable", {63'd0, stable_bad}, 64'd0);
        chk("wr_pulses", wr_cnt - wr0, to ? 0 : 1);
        if (!to) exp_reg[d] = res;
        chk("rf_dst_value", rf[d], exp_reg[d]);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_outputs",
            {ready, EN, RD, WR, ex_valid, done, err, so1, so2, si1}, {1'b1, 6'd0, 12'd0});
        chk("reset_data", I1 | ex_a | ex_b, 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) preload(4'(i), {$urandom, $urandom});
        preload(4'd3, 64'h3FF0000000000000);
        preload(4'd5, 64'h4000000000000000);
        preload(4'd4, 64'h1);

        run_op(4'd7, 4'd3, 4'd5, 0, 64'h4000000000000000, 1'b0, 0);
        run_op(4'd7, 4'd3, 4'd5, 10, 64'h4000000000000000, 1'b0, 0);
        run_op(4'd9, 4'd3, 4'd5, -1, 64'hDEAD, 1'b0, 0);
        run_op(4'd10, 4'd3, 4'd5, 1, 64'h1111, 1'b1, 0);
        run_op(4'd11, 4'd10, 4'd5, 0, 64'h2222, 1'b1, 0);
        run_op(4'd12, 4'd11, 4'd10, 2, 64'h3333, 1'b0, 0);
        run_op(4'd8, 4'd3, 4'd5, 20, 64'h5555, 1'b0, 3);
        run_op(4'd4, 4'd4, 4'd5, 0, 64'hABCD0123, 1'b0, 0);
        run_op(4'd6, 4'd4, 4'd4, 1, 64'h77, 1'b0, 0);
        for (int i = 0; i < 10; i++)
            run_op(4'($urandom), 4'($urandom), 4'($urandom), $urandom_range(0, 4),
                   {$urandom, $urandom}, 1'($urandom), 0);
        run_op(4'd0, 4'd15, 4'd0, 0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 0);
        chk("rd_wr_never_both", {63'd0, rdwr_bad}, 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
